// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end feeding id_stage. Walks a sequential PC,
//   issues word-aligned fetch requests to the Icache under a credit limit,
//   buffers returned words with their PCs in a small in-order queue and
//   hands the queue head to ID with a valid/ready handshake. A redirect from
//   fc flushes the queue, marks every in-flight response for discard and
//   restarts fetch at the (word-aligned) target.
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   if_Icache_req_o/addr_o   fetch request and its address (fetch_pc)
//   Icache_req_ready_i       Icache accepts the request this cycle
//   Icache_resp_valid_i      in-order instruction return
//   Icache_inst_i            returned instruction word
//   fc_jump_flag_i/pc_i      one-cycle redirect strobe and target
//   if_inst_valid_o          queue head valid
//   if_inst_o, if_pc_o       queue head instruction and PC
//   id_ready_i               ID consumes the head this cycle
// ----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_Icache_req_o,
  output logic [31:0] if_Icache_addr_o,
  input  logic        Icache_req_ready_i,
  input  logic        Icache_resp_valid_i,
  input  logic [31:0] Icache_inst_i,
  input  logic        fc_jump_flag_i,
  input  logic [31:0] fc_jump_pc_i,
  output logic        if_inst_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  input  logic        id_ready_i
);

  localparam int PW = $clog2(DEPTH);
  // One width for every occupancy/credit counter; MAX_OUT <= DEPTH so
  // out_cnt and drop_cnt fit as well.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  fq_entry_t       mem [DEPTH];
  fq_entry_t       last_q;       // value shown while the queue is empty
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   q_cnt;        // valid queue entries
  logic [CW-1:0]   out_cnt;      // accepted requests not yet answered
  logic [CW-1:0]   drop_cnt;     // in-flight responses from a flushed stream
  logic [31:0]     fetch_pc;     // next address to request
  logic [31:0]     resp_pc;      // PC of the oldest live outstanding request

  logic            jump;
  logic [31:0]     jump_tgt;
  logic            resp_ok;
  logic [CW:0]     credit_sum;
  logic            req;
  logic            hs;
  logic            push;
  logic            pop;

  assign jump     = fc_jump_flag_i;
  assign jump_tgt = fc_jump_pc_i & ~32'h3;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok    = Icache_resp_valid_i && (out_cnt != '0);

  // Credits: an outstanding request always owns a queue slot, so a response
  // can never find the queue full.
  assign credit_sum = {1'b0, q_cnt} + {1'b0, out_cnt};

  // No new requests while stale responses are still draining; otherwise
  // resp_pc could not tell new-stream responses from old ones.
  assign req = !rst && !jump
            && (out_cnt < CW'(MAX_OUT))
            && (credit_sum < (CW+1)'(DEPTH))
            && (drop_cnt == '0);

  assign hs   = req && Icache_req_ready_i;
  assign push = resp_ok && (drop_cnt == '0) && !jump;
  assign pop  = (q_cnt != '0) && id_ready_i;

  assign if_Icache_req_o  = req;
  assign if_Icache_addr_o = fetch_pc;
  assign if_inst_valid_o  = (q_cnt != '0);
  // Head comes from registered storage only; an empty queue keeps showing
  // the last head that was presented.
  assign if_inst_o = (q_cnt != '0) ? mem[rd_ptr].inst : last_q.inst;
  assign if_pc_o   = (q_cnt != '0) ? mem[rd_ptr].pc   : last_q.pc;

  // Entry storage needs no reset: nothing reads it while q_cnt is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: resp_pc, inst: Icache_inst_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC_AL;
      resp_pc  <= RESET_PC_AL;
      q_cnt    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      last_q   <= '0;
    end else begin
      if (q_cnt != '0) last_q <= mem[rd_ptr];

      // hs is already gated off during a redirect.
      out_cnt <= out_cnt + CW'(hs) - CW'(resp_ok);

      if (jump) begin
        // Everything still in flight after this cycle belongs to the old
        // stream; a response arriving now is discarded on the spot.
        drop_cnt <= out_cnt - CW'(resp_ok);
        fetch_pc <= jump_tgt;
        resp_pc  <= jump_tgt;
        q_cnt    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (hs) fetch_pc <= fetch_pc + 32'd4;
        if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
